// File: rtl/alu_result_tx.sv
// UART-style serial transmitter for one 8-bit ALU result: start bit, 8 data bits LSB-first, stop bit.
// An invert flag captured at acceptance sends the complement of the byte instead.
module alu_result_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic       invert,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic [CW-1:0] cyc;
  logic          bit_end;

  // Handshake: a byte moves when din_valid && din_ready at a rising edge.
  // din_ready depends on state only, so the producer never sees a combinational path.
  assign din_ready = (state == IDLE);
  assign bit_end   = (cyc == CYC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= 8'h00;
      bit_idx <= 3'd0;
      cyc     <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (din_valid) begin
            shreg   <= invert ? ~din : din;
            state   <= START;
            cyc     <= '0;
            bit_idx <= 3'd0;
            tx      <= 1'b0;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            cyc     <= '0;
            bit_idx <= 3'd0;
            tx      <= shreg[0];
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cyc <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[bit_idx + 3'd1];
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            // done lands in the first IDLE cycle, where din_ready is already high.
            state <= IDLE;
            cyc   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_tx.sv
// Directed bench for alu_result_tx: table of single frames plus hand-written
// back-to-back, busy-input and reset corner sequences.
module tb_alu_result_tx;

  localparam int C = 4;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       invert;
  logic       tx;
  logic       busy;
  logic       done;

  int n_vec;
  int n_err;

  alu_result_tx #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .invert    (invert),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic       invert;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string name, input logic exp_done);
    chk({name, ".tx"}, tx, 1'b1);
    chk({name, ".busy"}, busy, 1'b0);
    chk({name, ".done"}, done, exp_done);
    chk({name, ".ready"}, din_ready, 1'b1);
  endtask

  // Called at a negedge where din/din_valid are already set so the next posedge accepts.
  // noise_lo >= 0 drives din=FF, din_valid=1 for 5 frame cycles starting there.
  task automatic check_frame(input logic [7:0] exp_byte, input bit keep_valid, input int noise_lo);
    logic exp_tx;
    int seg;
    for (int k = 0; k < 10 * C; k++) begin
      @(negedge clk);
      if (noise_lo >= 0 && k >= noise_lo && k < noise_lo + 5) begin
        din = 8'hFF;
        din_valid = 1'b1;
      end else if (!keep_valid) begin
        din_valid = 1'b0;
      end
      seg = k / C;
      if (seg == 0) exp_tx = 1'b0;
      else if (seg == 9) exp_tx = 1'b1;
      else exp_tx = exp_byte[seg-1];
      chk($sformatf("frame%02h.k%0d.tx", exp_byte, k), tx, exp_tx);
      chk("frame.busy", busy, 1'b1);
      chk("frame.done", done, 1'b0);
      chk("frame.ready", din_ready, 1'b0);
    end
    @(negedge clk);
    chk_idle("done_cycle", 1'b1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    tbl[0] = '{din: 8'hA5, invert: 1'b0, exp_byte: 8'hA5};
    tbl[1] = '{din: 8'h0F, invert: 1'b1, exp_byte: 8'hF0};
    tbl[2] = '{din: 8'h00, invert: 1'b0, exp_byte: 8'h00};
    tbl[3] = '{din: 8'hFF, invert: 1'b1, exp_byte: 8'h00};
    tbl[4] = '{din: 8'h6E, invert: 1'b1, exp_byte: 8'h91};

    // reset with din_valid high: nothing may be accepted
    rst = 1'b1;
    din = 8'hAA;
    din_valid = 1'b1;
    invert = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_idle("reset", 1'b0);
    end
    rst = 1'b0;
    din_valid = 1'b0;
    @(negedge clk);
    chk_idle("post_reset", 1'b0);

    // table-driven single frames
    foreach (tbl[i]) begin
      din = tbl[i].din;
      invert = tbl[i].invert;
      din_valid = 1'b1;
      check_frame(tbl[i].exp_byte, 1'b0, -1);
      @(negedge clk);
      chk_idle("gap", 1'b0);
    end

    // back-to-back: valid held high, second byte accepted in the done cycle
    din = 8'h3C;
    invert = 1'b0;
    din_valid = 1'b1;
    check_frame(8'h3C, 1'b1, -1);
    din = 8'hC3;
    check_frame(8'hC3, 1'b0, -1);
    @(negedge clk);
    chk_idle("b2b_after", 1'b0);

    // din_valid while busy is ignored; changes to din/invert do not disturb the frame
    din = 8'h55;
    invert = 1'b0;
    din_valid = 1'b1;
    check_frame(8'h55, 1'b0, 10);
    @(negedge clk);
    chk_idle("busy_in_after", 1'b0);

    // reset during data bit 3
    din = 8'h3C;
    din_valid = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      din_valid = 1'b0;
      invert = 1'b1;
    end
    chk("midrst.pre_busy", busy, 1'b1);
    chk("midrst.pre_tx_bit3", tx, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("midrst", 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk_idle("midrst_quiet", 1'b0);
    end
    din = 8'h81;
    invert = 1'b0;
    din_valid = 1'b1;
    check_frame(8'h81, 1'b0, -1);
    @(negedge clk);
    chk_idle("final", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_result_tx.md
Name: alu_result_tx

Overview:
Serial transmitter for the 8-bit ALU datapath. It accepts one 8-bit ALU result through a valid/ready handshake and shifts it out on a single line as a UART-style frame: one start bit, 8 data bits LSB-first, one stop bit. An optional invert control sends the bitwise complement of the captured byte, so NOT results can be produced at the port without a separate datapath stage. It sits between the ALU result bus and the board/test serial pin.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit; legal range >= 1.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
din  input  8  ALU result byte to transmit
din_valid  input  1  din is valid this cycle
din_ready  output  1  high only in IDLE; a transfer occurs when din_valid && din_ready at a rising edge
invert  input  1  sampled with din at acceptance; 1 = transmit ~din
tx  output  1  serial line; idles high
busy  output  1  high while a frame is in progress (START, DATA, STOP)
done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst. No asynchronous reset.
- Reset values: tx=1, busy=0, done=0, din_ready=1, state=IDLE, shift register=0x00, bit and cycle counters=0.
- The FSM has four states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, din_ready=1, busy=0.
  - On handshake, capture the shift register as invert ? ~din : din, then go to START.
- START:
  - tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx = shreg[bit index] for CLKS_PER_BIT cycles per bit, bits 0..7 in order.
  - After bit 7 completes, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - done=1 for exactly one cycle, the first IDLE cycle after STOP. din_ready is also 1 in that cycle.
- Latency: tx first goes low in the cycle after the acceptance edge. The frame occupies exactly 10*CLKS_PER_BIT cycles. done follows the last stop cycle by one cycle.
- Back-to-back:
  - If din_valid stays high, the next byte is accepted in the IDLE/done cycle.
  - This gives exactly one idle-high cycle between frames, so the frame period is 10*CLKS_PER_BIT+1.
- din_valid while busy: ignored. din_ready=0, no capture, and the frame in progress is unaffected.
- Changes to din or invert after acceptance have no effect on the frame in progress.
- The cycle counter wraps from CLKS_PER_BIT-1 to 0 at each bit boundary. With CLKS_PER_BIT=1 each bit lasts one cycle and the counter stays 0.
- Reset mid-frame: at the next edge, tx=1, busy=0, done=0, state=IDLE. The partial frame is abandoned and no done pulse is generated.
- Reset has priority over a simultaneous handshake: a byte presented in the reset cycle is not accepted.
- Outputs are registered. tx, busy and done have no combinational path from inputs. din_ready is decoded from state only.

Test Plan:
- Reset: assert rst for 2 cycles with din_valid=1 -> tx=1, busy=0, done=0, din_ready=1, and no frame starts.
- Single frame (CLKS_PER_BIT=4): din=0xA5, invert=0 -> tx carries 0 (start), then data bits 1,0,1,0,0,1,0,1, then 1 (stop); each level held 4 cycles (40 cycles total); done pulses one cycle later; busy high for those 40 cycles.
- Invert: din=0x0F, invert=1 -> data bits transmitted 0,0,0,0,1,1,1,1 (0xF0 LSB-first).
- Back-to-back: din_valid held high with 0x3C then 0xC3 -> two frames separated by exactly one tx=1 IDLE cycle; done pulses coincide with the second acceptance.
- Busy input: during a 0x55 frame, drive din=0xFF, din_valid=1 for 5 cycles -> no capture, and the frame bits remain 0x55.
- Reset mid-frame: assert rst during data bit 3 -> tx=1 and busy=0 at the next edge; no done pulse; a new 0x81 frame then transmits correctly.
